f_accum_reduce: RTL and testbench

- Parametrised successor to the windowed running-max accumulator unit.
- Reduces a stream of DATA_W-bit samples over fixed-length windows (stride) using a selectable operator: max, min, or saturating sum.
- Supports signed or unsigned comparison.
- Reports the in-window index of the winning element, plus a one-cycle valid pulse when a window completes.
- Sits in the Versat datapath as a functional unit feeding pooling and reduction layers.

---
 rtl/f_accum_reduce_if.sv | 26 ++
 rtl/f_accum_reduce.sv | 134 +++++++++++++
 tb/tb_f_accum_reduce.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/f_accum_reduce_if.sv
// Stream/control bundle for the windowed reduction unit: sample, window setup and results.
interface f_accum_reduce_if #(
   parameter int DATA_W  = 32,
   parameter int DELAY_W = 7
) ();
   logic               run;
   logic               running;
   logic [1:0]         mode;
   logic               signed_en;
   logic [DELAY_W-1:0] strideMinusOne;
   logic [DELAY_W-1:0] delay0;
   logic [DATA_W-1:0]  in0;
   logic [DATA_W-1:0]  out0;
   logic [DELAY_W-1:0] out_idx;
   logic               out_valid;

   modport master (
      output run, running, mode, signed_en, strideMinusOne, delay0, in0,
      input  out0, out_idx, out_valid
   );

   modport slave (
      input  run, running, mode, signed_en, strideMinusOne, delay0, in0,
      output out0, out_idx, out_valid
   );
endinterface

// File: rtl/f_accum_reduce.sv
// Windowed max/min/saturating-sum reducer with winner index and a per-window valid pulse.
module f_accum_reduce #(
   parameter int DATA_W  = 32,
   parameter int DELAY_W = 7
) (
   input logic           clk,
   input logic           rst,
   f_accum_reduce_if.slave bus
);

   logic [DELAY_W-1:0]       delay;
   logic [DELAY_W-1:0]       idx_cnt;
   logic                     started;
   logic signed [DATA_W-1:0] acc_p1;
   logic [DELAY_W-1:0]       win_idx_p1;
   logic                     vld_p1;

   logic                     store;
   logic                     win_start;
   logic                     last_elem;
   logic signed [DATA_W-1:0] sample;
   logic signed [DATA_W-1:0] acc_nx;
   logic [DELAY_W-1:0]       idx_nx;

   function automatic logic wins(input logic signed [DATA_W-1:0] cand,
                                 input logic signed [DATA_W-1:0] cur,
                                 input logic sgn,
                                 input logic is_min);
      logic lt;
      logic gt;
      if (sgn) begin
         lt = cand < cur;
         gt = cand > cur;
      end else begin
         lt = $unsigned(cand) < $unsigned(cur);
         gt = $unsigned(cand) > $unsigned(cur);
      end
      return is_min ? lt : gt;
   endfunction

   function automatic logic signed [DATA_W-1:0] sat_add(input logic signed [DATA_W-1:0] a,
                                                        input logic signed [DATA_W-1:0] b,
                                                        input logic sgn);
      logic signed [DATA_W:0] s_sum;
      logic [DATA_W:0]        u_sum;
      logic signed [DATA_W-1:0] res;
      s_sum = $signed({a[DATA_W-1], a}) + $signed({b[DATA_W-1], b});
      u_sum = {1'b0, a} + {1'b0, b};
      if (sgn) begin
         // Top two bits disagree only on signed overflow; the carry-out gives the direction.
         if (s_sum[DATA_W] != s_sum[DATA_W-1])
            res = s_sum[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
         else
            res = s_sum[DATA_W-1:0];
      end else begin
         res = u_sum[DATA_W] ? {DATA_W{1'b1}} : u_sum[DATA_W-1:0];
      end
      return res;
   endfunction

   assign sample = bus.in0;

   always_comb begin
      store     = (delay == '0);
      win_start = bus.running && store;
      last_elem = started && bus.running && !bus.run &&
                  ((delay == DELAY_W'(1)) || (store && (bus.strideMinusOne == '0)));
      acc_nx    = acc_p1;
      idx_nx    = win_idx_p1;
      if (win_start) begin
         acc_nx = sample;
         idx_nx = '0;
      end else begin
         case (bus.mode)
            2'b01: begin
               if (wins(sample, acc_p1, bus.signed_en, 1'b1)) begin
                  acc_nx = sample;
                  idx_nx = idx_cnt;
               end
            end
            2'b10: begin
               acc_nx = sat_add(acc_p1, sample, bus.signed_en);
               idx_nx = '0;
            end
            default: begin
               if (wins(sample, acc_p1, bus.signed_en, 1'b0)) begin
                  acc_nx = sample;
                  idx_nx = idx_cnt;
               end
            end
         endcase
      end
   end

   // Stage p1: accumulator, winner index and window-complete flag
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         delay      <= '0;
         idx_cnt    <= '0;
         started    <= 1'b0;
         acc_p1     <= '0;
         win_idx_p1 <= '0;
         vld_p1     <= 1'b0;
      end else begin
         if (bus.run)
            delay <= bus.delay0;
         else if (!store)
            delay <= delay - DELAY_W'(1);
         else
            delay <= bus.strideMinusOne;

         if (bus.running) begin
            acc_p1     <= acc_nx;
            win_idx_p1 <= idx_nx;
            idx_cnt    <= win_start ? DELAY_W'(1) : idx_cnt + DELAY_W'(1);
            if (win_start)
               started <= 1'b1;
         end

         // A run pulse abandons any open window; acc is left to be overwritten at the next start.
         if (bus.run) begin
            started <= 1'b0;
            idx_cnt <= '0;
         end

         vld_p1 <= last_elem;
      end
   end

   assign bus.out0      = acc_p1;
   assign bus.out_idx   = win_idx_p1;
   assign bus.out_valid = vld_p1;

endmodule

// File: tb/tb_f_accum_reduce.sv
// Directed-vector bench for f_accum_reduce: one task per scenario, inline checks.
module tb_f_accum_reduce;

   localparam int DATA_W  = 32;
   localparam int DELAY_W = 7;

   logic clk;
   logic rst;
   int   tests;
   int   fails;

   f_accum_reduce_if #(.DATA_W(DATA_W), .DELAY_W(DELAY_W)) bus ();

   f_accum_reduce #(.DATA_W(DATA_W), .DELAY_W(DELAY_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic do_run(input logic [DELAY_W-1:0] d0, input logic [DELAY_W-1:0] smo,
                         input logic [1:0] md, input logic sgn);
      bus.delay0         = d0;
      bus.strideMinusOne = smo;
      bus.mode           = md;
      bus.signed_en      = sgn;
      bus.running        = 1'b0;
      bus.run            = 1'b1;
      step();
      bus.run            = 1'b0;
   endtask

   task automatic feed(input logic [DATA_W-1:0] v);
      bus.in0     = v;
      bus.running = 1'b1;
      step();
   endtask

   task automatic idle;
      bus.running = 1'b0;
      bus.in0     = 32'd100;
      step();
   endtask

   task automatic test_reset;
      tests++; if (bus.out0 !== 32'd0) begin fails++; $display("FAIL reset_out0: got %h want 0", bus.out0); end
      tests++; if (bus.out_idx !== 7'd0) begin fails++; $display("FAIL reset_idx: got %0d want 0", bus.out_idx); end
      tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", bus.out_valid); end
   endtask

   task automatic test_signed_max;
      int nv;
      logic [DATA_W-1:0] vec [4];
      vec = '{32'd5, 32'hFFFF_FFFE, 32'd9, 32'd9};
      nv = 0;
      do_run(7'd0, 7'd3, 2'b00, 1'b1);
      for (int i = 0; i < 4; i++) begin
         feed(vec[i]);
         nv += int'(bus.out_valid);
      end
      tests++; if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL smax_valid: got %b want 1", bus.out_valid); end
      tests++; if (bus.out0 !== 32'd9) begin fails++; $display("FAIL smax_out0: got %h want 9", bus.out0); end
      tests++; if (bus.out_idx !== 7'd2) begin fails++; $display("FAIL smax_idx: got %0d want 2", bus.out_idx); end
      idle();
      nv += int'(bus.out_valid);
      tests++; if (nv != 1) begin fails++; $display("FAIL smax_pulses: got %0d want 1", nv); end
   endtask

   task automatic test_min;
      logic [DATA_W-1:0] vec [4];
      vec = '{32'h10, 32'hFFFF_FFF0, 32'h03, 32'h20};
      do_run(7'd0, 7'd3, 2'b01, 1'b0);
      for (int i = 0; i < 4; i++) feed(vec[i]);
      tests++; if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL umin_valid: got %b want 1", bus.out_valid); end
      tests++; if (bus.out0 !== 32'h3) begin fails++; $display("FAIL umin_out0: got %h want 3", bus.out0); end
      tests++; if (bus.out_idx !== 7'd2) begin fails++; $display("FAIL umin_idx: got %0d want 2", bus.out_idx); end
      do_run(7'd0, 7'd3, 2'b01, 1'b1);
      for (int i = 0; i < 4; i++) feed(vec[i]);
      tests++; if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL smin_valid: got %b want 1", bus.out_valid); end
      tests++; if (bus.out0 !== 32'hFFFF_FFF0) begin fails++; $display("FAIL smin_out0: got %h want fffffff0", bus.out0); end
      tests++; if (bus.out_idx !== 7'd1) begin fails++; $display("FAIL smin_idx: got %0d want 1", bus.out_idx); end
   endtask

   task automatic test_sat_sum;
      do_run(7'd0, 7'd1, 2'b10, 1'b1);
      feed(32'h7FFF_FFF0);
      feed(32'h0000_0100);
      tests++; if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL ssum_valid: got %b want 1", bus.out_valid); end
      tests++; if (bus.out0 !== 32'h7FFF_FFFF) begin fails++; $display("FAIL ssum_pos_out0: got %h want 7fffffff", bus.out0); end
      tests++; if (bus.out_idx !== 7'd0) begin fails++; $display("FAIL ssum_idx: got %0d want 0", bus.out_idx); end
      do_run(7'd0, 7'd1, 2'b10, 1'b1);
      feed(32'h8000_0010);
      feed(32'hFFFF_FF00);
      tests++; if (bus.out0 !== 32'h8000_0000) begin fails++; $display("FAIL ssum_neg_out0: got %h want 80000000", bus.out0); end
      do_run(7'd0, 7'd1, 2'b10, 1'b0);
      feed(32'hFFFF_FF00);
      feed(32'h0000_0200);
      tests++; if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL usum_valid: got %b want 1", bus.out_valid); end
      tests++; if (bus.out0 !== 32'hFFFF_FFFF) begin fails++; $display("FAIL usum_out0: got %h want ffffffff", bus.out0); end
      tests++; if (bus.out_idx !== 7'd0) begin fails++; $display("FAIL usum_idx: got %0d want 0", bus.out_idx); end
   endtask

   task automatic test_back_to_back;
      do_run(7'd2, 7'd1, 2'b00, 1'b1);
      feed(32'd1);
      feed(32'd2);
      tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL b2b_prewin_valid: got %b want 0", bus.out_valid); end
      feed(32'd3);
      feed(32'd1);
      tests++; if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL b2b_w1_valid: got %b want 1", bus.out_valid); end
      tests++; if (bus.out0 !== 32'd3) begin fails++; $display("FAIL b2b_w1_out0: got %h want 3", bus.out0); end
      tests++; if (bus.out_idx !== 7'd0) begin fails++; $display("FAIL b2b_w1_idx: got %0d want 0", bus.out_idx); end
      feed(32'd4);
      tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL b2b_gap_valid: got %b want 0", bus.out_valid); end
      feed(32'd7);
      tests++; if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL b2b_w2_valid: got %b want 1", bus.out_valid); end
      tests++; if (bus.out0 !== 32'd7) begin fails++; $display("FAIL b2b_w2_out0: got %h want 7", bus.out0); end
      tests++; if (bus.out_idx !== 7'd1) begin fails++; $display("FAIL b2b_w2_idx: got %0d want 1", bus.out_idx); end
   endtask

   task automatic test_stride1;
      logic [DATA_W-1:0] vec [3];
      logic              vexp [3];
      vec  = '{32'd4, 32'd8, 32'd1};
      vexp = '{1'b0, 1'b1, 1'b1};
      do_run(7'd0, 7'd0, 2'b00, 1'b1);
      for (int i = 0; i < 3; i++) begin
         feed(vec[i]);
         tests++; if (bus.out0 !== vec[i]) begin fails++; $display("FAIL s1_out0[%0d]: got %h want %h", i, bus.out0, vec[i]); end
         tests++; if (bus.out_valid !== vexp[i]) begin fails++; $display("FAIL s1_valid[%0d]: got %b want %b", i, bus.out_valid, vexp[i]); end
      end
   endtask

   task automatic test_run_abort;
      do_run(7'd0, 7'd3, 2'b00, 1'b1);
      feed(32'd5);
      feed(32'd6);
      do_run(7'd1, 7'd3, 2'b00, 1'b1);
      feed(32'd99);
      tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL abort_valid: got %b want 0", bus.out_valid); end
      feed(32'd10);
      feed(32'd2);
      feed(32'd30);
      tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL abort_early_valid: got %b want 0", bus.out_valid); end
      feed(32'd4);
      tests++; if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL abort_new_valid: got %b want 1", bus.out_valid); end
      tests++; if (bus.out0 !== 32'd30) begin fails++; $display("FAIL abort_new_out0: got %h want 1e", bus.out0); end
      tests++; if (bus.out_idx !== 7'd2) begin fails++; $display("FAIL abort_new_idx: got %0d want 2", bus.out_idx); end
   endtask

   task automatic test_running_gap;
      do_run(7'd0, 7'd3, 2'b00, 1'b1);
      feed(32'd3);
      feed(32'd8);
      for (int i = 0; i < 3; i++) begin
         idle();
         tests++; if (bus.out0 !== 32'd8) begin fails++; $display("FAIL gap_hold_out0[%0d]: got %h want 8", i, bus.out0); end
         tests++; if (bus.out_idx !== 7'd1) begin fails++; $display("FAIL gap_hold_idx[%0d]: got %0d want 1", i, bus.out_idx); end
      end
      feed(32'd9);
      feed(32'd1);
      feed(32'd2);
      tests++; if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL gap_valid: got %b want 1", bus.out_valid); end
      tests++; if (bus.out0 !== 32'd9) begin fails++; $display("FAIL gap_out0: got %h want 9", bus.out0); end
      tests++; if (bus.out_idx !== 7'd2) begin fails++; $display("FAIL gap_idx: got %0d want 2", bus.out_idx); end
   endtask

   task automatic test_async_reset;
      do_run(7'd0, 7'd0, 2'b00, 1'b1);
      feed(32'd4);
      feed(32'd8);
      tests++; if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL arst_pre_valid: got %b want 1", bus.out_valid); end
      #2;
      rst = 1'b1;
      #1;
      tests++; if (bus.out0 !== 32'd0) begin fails++; $display("FAIL arst_out0: got %h want 0", bus.out0); end
      tests++; if (bus.out_idx !== 7'd0) begin fails++; $display("FAIL arst_idx: got %0d want 0", bus.out_idx); end
      tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL arst_valid: got %b want 0", bus.out_valid); end
      step();
      rst = 1'b0;
      bus.running = 1'b0;
      step();
      tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL arst_post_valid: got %b want 0", bus.out_valid); end
   endtask

   initial begin
      tests = 0;
      fails = 0;
      rst = 1'b1;
      bus.run = 1'b0;
      bus.running = 1'b0;
      bus.mode = 2'b00;
      bus.signed_en = 1'b0;
      bus.strideMinusOne = '0;
      bus.delay0 = '0;
      bus.in0 = '0;
      #2;
      test_reset();
      step();
      rst = 1'b0;
      step();
      test_signed_max();
      test_min();
      test_sat_sum();
      test_back_to_back();
      test_stride1();
      test_run_abort();
      test_running_gap();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
